// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: pipeline control, instruction memory handshake and IF/ID output bundle
interface fetch_sequencer_if #(
  parameter int MEM_WORDS = 1024,
  parameter int AW = $clog2(MEM_WORDS)
);
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic [31:0]   if_nextpc;
  logic          halted;
  logic          err_misaligned;
  logic [31:0]   fetch_count;
  logic [31:0]   stall_count;
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_nextpc,
           halted, err_misaligned, fetch_count, stall_count
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_nextpc,
           halted, err_misaligned, fetch_count, stall_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF stage PC owner, imem fetch handshake, stall hold, redirect flush, end-address halt
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] HALT_PC = 32'd48,
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.master bus
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic {FETCH, HALT} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, npc_q, npc_d, fcnt_q, scnt_q;
  logic valid_q, valid_d, err_q, err_d, req, xfer, consume, redir;
  assign redir = (state_q == FETCH) && bus.redirect_valid;
  assign req = (state_q == FETCH) && !(valid_q && bus.stall) && !bus.redirect_valid;
  assign xfer = req && bus.imem_ready;
  assign consume = valid_q && !bus.stall;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    npc_d = npc_q;
    valid_d = valid_q;
    err_d = err_q;
    if (redir) begin
      valid_d = 1'b0;
      err_d = err_q || (bus.redirect_pc[1:0] != 2'b00);
      pc_d = (bus.redirect_pc[1:0] == 2'b00) ? bus.redirect_pc : pc_q;
      state_d = (bus.redirect_pc[1:0] != 2'b00 || bus.redirect_pc >= HALT_PC) ? HALT : FETCH;
    end else if (xfer) begin
      instr_d = bus.imem_rdata;
      ipc_d = pc_q;
      npc_d = pc_q + 32'd4;
      valid_d = 1'b1;
      pc_d = pc_q + 32'd4;
      state_d = (pc_q + 32'd4 == HALT_PC) ? HALT : FETCH;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= '0;
      ipc_q <= '0;
      npc_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
      npc_q <= npc_d;
      valid_q <= valid_d;
      err_q <= err_d;
      fcnt_q <= fcnt_q + {31'd0, consume};
      scnt_q <= scnt_q + {31'd0, valid_q && bus.stall};
    end
  end
  assign bus.imem_req = req;
  assign bus.imem_addr = pc_q[AW+1:2];
  assign bus.if_valid = valid_q;
  assign bus.if_instr = instr_q;
  assign bus.if_pc = ipc_q;
  assign bus.if_nextpc = npc_q;
  assign bus.halted = (state_q == HALT);
  assign bus.err_misaligned = err_q;
  assign bus.fetch_count = fcnt_q;
  assign bus.stall_count = scnt_q;
endmodule
